// File: rtl/mips_mem_arb_if.sv
`default_nettype none
// ============================================================================
// Module      : mips_mem_arb_if
// Description : Bus bundle for the instruction/data memory arbiter. Carries
//               the I-side and D-side request/response channels and the
//               shared single-port memory channel.
//   slave  modport : seen by the arbiter (takes requests, drives memory)
//   master modport : seen by the pipeline/memory environment
//   I/D side   : x_req, x_write, x_addr, x_wdata -> ; <- x_rdata, x_done
//   memory     : mem_read, mem_write, mem_addr, mem_wdata, mem_err -> ;
//                <- mem_rdata, mem_ready
// Revision    : 1.0 - initial release
// ============================================================================
interface mips_mem_arb_if #(
    parameter int AW = 30,
    parameter int DW = 32
);
    // instruction-fetch side
    logic          i_req;
    logic          i_write;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_wdata;
    logic [DW-1:0] i_rdata;
    logic          i_done;
    // data-memory side
    logic          d_req;
    logic          d_write;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_done;
    // shared memory port
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;
    logic          mem_err;

    modport slave (
        input  i_req, i_write, i_addr, i_wdata,
        input  d_req, d_write, d_addr, d_wdata,
        input  mem_rdata, mem_ready,
        output i_rdata, i_done, d_rdata, d_done,
        output mem_read, mem_write, mem_addr, mem_wdata, mem_err
    );

    modport master (
        output i_req, i_write, i_addr, i_wdata,
        output d_req, d_write, d_addr, d_wdata,
        output mem_rdata, mem_ready,
        input  i_rdata, i_done, d_rdata, d_done,
        input  mem_read, mem_write, mem_addr, mem_wdata, mem_err
    );
endinterface
`default_nettype wire

// File: rtl/mips_mem_arb.sv
`default_nettype none
// ============================================================================
// Module      : mips_mem_arb
// Description : Shares one single-port memory bus between the instruction
//               fetch side and the data memory side. One single-word
//               transaction at a time; address/write data of the winner are
//               latched at grant and held until completion.
// Ports       : clk    - clock, rising edge
//               rst_n  - asynchronous active-low reset
//               bus    - mips_mem_arb_if.slave (I side, D side, memory port)
// Parameters  : AW (word address width), DW (data width),
//               RR (0: D has fixed priority, 1: round-robin),
//               TO_W (timeout counter width, timeout build only)
// Build option: MIPS_MEM_ARB_TIMEOUT_EN - when defined, a BUSY phase that
//               sees no mem_ready for 2^TO_W-1 cycles is abandoned with a
//               mem_err pulse and a done pulse carrying zero read data.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_mem_arb #(
    parameter int AW   = 30,
    parameter int DW   = 32,
    parameter int RR   = 0,
    parameter int TO_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    mips_mem_arb_if.slave       bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_next;

    logic          r_rr_last;   // side granted most recently: 0 = I, 1 = D
    logic          r_write;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;

    logic          w_grant_i;
    logic          w_grant_d;
    logic          w_busy;
    logic          w_timeout;
    logic          w_finish;
    logic          w_rd_ok;

    // ------------------------------------------------------------------
    // Arbitration, only evaluated while IDLE
    // ------------------------------------------------------------------
    always_comb begin
        w_grant_i = 1'b0;
        w_grant_d = 1'b0;
        if (r_state == IDLE) begin
            if (bus.i_req && bus.d_req) begin
                // With round-robin, D wins when I was served last; the
                // reset value of r_rr_last therefore lets D win the first tie.
                if ((RR == 0) || !r_rr_last) begin
                    w_grant_d = 1'b1;
                end else begin
                    w_grant_i = 1'b1;
                end
            end else if (bus.d_req) begin
                w_grant_d = 1'b1;
            end else if (bus.i_req) begin
                w_grant_i = 1'b1;
            end
        end
    end

    assign w_busy   = (r_state != IDLE);
    assign w_finish = w_busy && (bus.mem_ready || w_timeout);
    assign w_rd_ok  = bus.mem_ready && !r_write;

    // ------------------------------------------------------------------
    // Optional BUSY timeout
    // ------------------------------------------------------------------
`ifdef MIPS_MEM_ARB_TIMEOUT_EN
    logic [TO_W-1:0] r_to_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt <= '0;
        end else if (w_grant_i || w_grant_d) begin
            r_to_cnt <= '0;
        end else if (w_busy && !bus.mem_ready && !w_timeout) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    // A mem_ready arriving in the terminal count cycle still completes
    // normally, so the timeout is qualified with !mem_ready.
    assign w_timeout = w_busy && !bus.mem_ready && (&r_to_cnt);
`else
    assign w_timeout = 1'b0;

    // The counter width only matters in the timeout build; nothing is
    // generated for it here.
    if (TO_W < 1) begin : g_to_w_unused
    end
`endif

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Every completion returns to IDLE, which gives the mandatory idle
    // cycle in which both sides are re-arbitrated.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_grant_d) begin
                    w_next = BUSY_D;
                end else if (w_grant_i) begin
                    w_next = BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                if (w_finish) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Grant-time capture of the winner's transaction
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_last <= 1'b0;
            r_write   <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
        end else if (w_grant_d) begin
            r_rr_last <= 1'b1;
            r_write   <= bus.d_write;
            r_addr    <= bus.d_addr;
            r_wdata   <= bus.d_wdata;
        end else if (w_grant_i) begin
            r_rr_last <= 1'b0;
            r_write   <= bus.i_write;
            r_addr    <= bus.i_addr;
            r_wdata   <= bus.i_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Outputs. Strobes decode straight from the state register so that an
    // asynchronous reset drops them immediately.
    // ------------------------------------------------------------------
    assign bus.mem_read  = w_busy && !r_write && !w_timeout;
    assign bus.mem_write = w_busy &&  r_write && !w_timeout;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;
    assign bus.mem_err   = w_timeout;

    assign bus.i_done  = (r_state == BUSY_I) && w_finish;
    assign bus.d_done  = (r_state == BUSY_D) && w_finish;
    assign bus.i_rdata = ((r_state == BUSY_I) && w_rd_ok) ? bus.mem_rdata : '0;
    assign bus.d_rdata = ((r_state == BUSY_D) && w_rd_ok) ? bus.mem_rdata : '0;

endmodule
`default_nettype wire
